// File: rtl/wr_commit_pkg.sv
// Shared definitions for the write-back/commit stage.
// Exception-info layout, CACHE op codes, FSM states and fetch redirect helper.
package wr_commit_pkg;

  localparam int EX_INFO_W  = 32;
  localparam int EX_VALID   = 0;
  localparam int EXCCODE_LO = 1;
  localparam int EXCCODE_HI = 5;

  localparam logic [4:0] CACHE_NONE        = 5'h00;
  localparam logic [4:0] CACHE_D_IDX_WBINV = 5'h01;
  localparam logic [4:0] CACHE_I_IDX_STTAG = 5'h08;
  localparam logic [4:0] CACHE_D_IDX_STTAG = 5'h09;
  localparam logic [4:0] CACHE_I_HIT_INV   = 5'h10;
  localparam logic [4:0] CACHE_D_HIT_INV   = 5'h11;
  localparam logic [4:0] CACHE_D_HIT_WBINV = 5'h15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LWAIT = 2'd1,
    ST_CREQ  = 2'd2,
    ST_CDONE = 2'd3
  } wr_state_e;

  // A zero PC means the bundle is corrupt; redirect to the boot vector.
  function automatic logic [31:0] next_fetch(
    input logic [31:0] pc,
    input logic [31:0] fallback
  );
    return (pc == 32'h0) ? fallback : pc + 32'd4;
  endfunction

endpackage

// File: rtl/wr_cache_seq.sv
// CACHE instruction handshake: request until ack, then one done cycle.
// Request, op and address are registered and held stable while pending.
import wr_commit_pkg::*;

module wr_cache_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] paddr,
  input  logic        ack,
  output logic        cache_req,
  output logic [4:0]  cache_op_o,
  output logic [31:0] cache_addr,
  output logic        busy,
  output logic        done
);

  wr_state_e state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cache_req  <= 1'b0;
      cache_op_o <= 5'h0;
      cache_addr <= 32'h0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_CREQ;
            cache_req  <= 1'b1;
            cache_op_o <= op;
            cache_addr <= paddr;
          end
        end
        ST_CREQ: begin
          if (ack) begin
            state      <= ST_CDONE;
            cache_req  <= 1'b0;
            cache_op_o <= 5'h0;
            cache_addr <= 32'h0;
          end
        end
        ST_CDONE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_CDONE);

endmodule

// File: rtl/wr_commit.sv
// Write-back/commit stage: GPR/CP0 commit, exceptions, refetch, CACHE ops.
// Optional DEBUG_TRACE_EN adds the debug_wb_* retirement trace outputs.
import wr_commit_pkg::*;

module wr_commit #(
  parameter logic [31:0] RESET_PC_NEXT = 32'hBFC0_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          WR_pc,
  input  logic [31:0]          WR_busW_inner,
  input  logic [31:0]          WR_badvaddr,
  input  logic [4:0]           WR_write_reg,
  input  logic [3:0]           WR_reg_write_en,
  input  logic                 WR_cp0_write_en,
  input  logic [7:0]           WR_cp0_write_reg,
  input  logic [EX_INFO_W-1:0] WR_exception_info,
  input  logic                 WR_inst_refetch,
  input  logic                 WR_unhit,
  input  logic [4:0]           WR_cache_op,
  input  logic                 WR_crefetch,
  input  logic [31:0]          WR_cache_paddr,
  input  logic                 dload_data_ok,
  input  logic [31:0]          dload_rdata,
  input  logic                 cache_ack,
  output logic                 WR_wr,
  output logic [3:0]           rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 cp0_we,
  output logic [7:0]           cp0_waddr,
  output logic [31:0]          cp0_wdata,
  output logic                 ex_commit,
  output logic [4:0]           ex_code,
  output logic [31:0]          ex_pc,
  output logic [31:0]          ex_badvaddr,
  output logic                 flush,
  output logic [31:0]          refetch_pc,
  output logic                 cache_req,
  output logic [4:0]           cache_op_o,
  output logic [31:0]          cache_addr
`ifdef DEBUG_TRACE_EN
  ,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
`endif
);

  wr_state_e   st;
  wr_state_e   nxt;
  logic        ex_v;
  logic        inst_v;
  logic        seq_start;
  logic        seq_req;
  logic [4:0]  seq_op;
  logic [31:0] seq_addr;
  logic        seq_busy;
  logic        seq_done;
  logic        unused_info;

  assign ex_v   = WR_exception_info[EX_VALID];
  assign inst_v = ex_v | (|WR_reg_write_en) | WR_cp0_write_en
                | (|WR_cache_op) | WR_inst_refetch;
  assign unused_info = ^WR_exception_info[EX_INFO_W-1:EXCCODE_HI+1];

  wr_cache_seq u_seq (
    .clk        (clk),
    .reset      (reset),
    .start      (seq_start),
    .op         (WR_cache_op),
    .paddr      (WR_cache_paddr),
    .ack        (cache_ack),
    .cache_req  (seq_req),
    .cache_op_o (seq_op),
    .cache_addr (seq_addr),
    .busy       (seq_busy),
    .done       (seq_done)
  );

  always_ff @(posedge clk) begin
    if (reset) st <= ST_IDLE;
    else       st <= nxt;
  end

  always_comb begin
    nxt         = st;
    seq_start   = 1'b0;
    WR_wr       = 1'b1;
    rf_we       = 4'h0;
    rf_waddr    = WR_write_reg;
    rf_wdata    = WR_busW_inner;
    cp0_we      = 1'b0;
    cp0_waddr   = WR_cp0_write_reg;
    cp0_wdata   = WR_busW_inner;
    ex_commit   = 1'b0;
    ex_code     = 5'h0;
    ex_pc       = 32'h0;
    ex_badvaddr = 32'h0;
    flush       = 1'b0;
    refetch_pc  = next_fetch(WR_pc, RESET_PC_NEXT);
    cache_req   = seq_req;
    cache_op_o  = seq_op;
    cache_addr  = seq_addr;
    if (reset) begin
      nxt        = ST_IDLE;
      rf_waddr   = 5'h0;
      rf_wdata   = 32'h0;
      cp0_waddr  = 8'h0;
      cp0_wdata  = 32'h0;
      refetch_pc = 32'h0;
      cache_req  = 1'b0;
      cache_op_o = 5'h0;
      cache_addr = 32'h0;
    end else begin
      unique case (1'b1)
        seq_busy: begin
          WR_wr = seq_done;
          flush = seq_done & WR_crefetch;
        end
        (st == ST_LWAIT): begin
          WR_wr = dload_data_ok;
          if (dload_data_ok) begin
            rf_we    = WR_reg_write_en;
            rf_wdata = dload_rdata;
            nxt      = ST_IDLE;
          end
        end
        default: begin
          if (ex_v) begin
            ex_commit   = 1'b1;
            flush       = 1'b1;
            ex_code     = WR_exception_info[EXCCODE_HI:EXCCODE_LO];
            ex_pc       = WR_pc;
            ex_badvaddr = WR_badvaddr;
          end else if (|WR_cache_op) begin
            WR_wr     = 1'b0;
            seq_start = 1'b1;
          end else if (WR_unhit) begin
            WR_wr = 1'b0;
            nxt   = ST_LWAIT;
          end else if (inst_v) begin
            rf_we  = WR_reg_write_en;
            cp0_we = WR_cp0_write_en;
            flush  = WR_inst_refetch;
          end
        end
      endcase
    end
  end

`ifdef DEBUG_TRACE_EN
  always_comb begin
    debug_wb_pc       = 32'h0;
    debug_wb_rf_wen   = 4'h0;
    debug_wb_rf_wnum  = 5'h0;
    debug_wb_rf_wdata = 32'h0;
    if (|rf_we) begin
      debug_wb_pc       = WR_pc;
      debug_wb_rf_wen   = rf_we;
      debug_wb_rf_wnum  = rf_waddr;
      debug_wb_rf_wdata = rf_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_wr_commit.sv
// Scoreboard bench for wr_commit: driver stamps expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wr_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] WR_pc, WR_busW_inner, WR_badvaddr, WR_cache_paddr;
  logic [4:0]  WR_write_reg, WR_cache_op;
  logic [3:0]  WR_reg_write_en;
  logic        WR_cp0_write_en, WR_inst_refetch, WR_unhit, WR_crefetch;
  logic [7:0]  WR_cp0_write_reg;
  logic [31:0] WR_exception_info;
  logic        dload_data_ok, cache_ack;
  logic [31:0] dload_rdata;
  logic        WR_wr, cp0_we, ex_commit, flush, cache_req;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr, ex_code, cache_op_o;
  logic [31:0] rf_wdata, cp0_wdata, ex_pc, ex_badvaddr;
  logic [31:0] refetch_pc, cache_addr;
  logic [7:0]  cp0_waddr;
`ifdef DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
`endif

  wr_commit dut (
    .clk(clk), .reset(reset),
    .WR_pc(WR_pc), .WR_busW_inner(WR_busW_inner),
    .WR_badvaddr(WR_badvaddr), .WR_write_reg(WR_write_reg),
    .WR_reg_write_en(WR_reg_write_en),
    .WR_cp0_write_en(WR_cp0_write_en),
    .WR_cp0_write_reg(WR_cp0_write_reg),
    .WR_exception_info(WR_exception_info),
    .WR_inst_refetch(WR_inst_refetch), .WR_unhit(WR_unhit),
    .WR_cache_op(WR_cache_op), .WR_crefetch(WR_crefetch),
    .WR_cache_paddr(WR_cache_paddr),
    .dload_data_ok(dload_data_ok), .dload_rdata(dload_rdata),
    .cache_ack(cache_ack), .WR_wr(WR_wr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .ex_commit(ex_commit), .ex_code(ex_code), .ex_pc(ex_pc),
    .ex_badvaddr(ex_badvaddr), .flush(flush),
    .refetch_pc(refetch_pc), .cache_req(cache_req),
    .cache_op_o(cache_op_o), .cache_addr(cache_addr)
`ifdef DEBUG_TRACE_EN
    ,
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    bit          rst;
    logic        wr;
    logic [3:0]  we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        cp0;
    logic        ex;
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] bva;
    logic        fl;
    logic [31:0] rpc;
    logic        req;
    logic [4:0]  op;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(string nm);
    exp_t e;
    e.cyc = 0; e.nm = nm; e.rst = 0;
    e.wr = 1; e.we = 0; e.wa = 0; e.wd = 0; e.cp0 = 0;
    e.ex = 0; e.code = 0; e.epc = 0; e.bva = 0;
    e.fl = 0; e.rpc = 0; e.req = 0; e.op = 0; e.addr = 0;
    return e;
  endfunction

  task automatic push(input exp_t e);
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    WR_pc = 32'h0; WR_busW_inner = 32'h0; WR_badvaddr = 32'h0;
    WR_write_reg = 5'h0; WR_reg_write_en = 4'h0;
    WR_cp0_write_en = 1'b0; WR_cp0_write_reg = 8'h0;
    WR_exception_info = 32'h0; WR_inst_refetch = 1'b0;
    WR_unhit = 1'b0; WR_cache_op = 5'h0; WR_crefetch = 1'b0;
    WR_cache_paddr = 32'h0; dload_data_ok = 1'b0;
    dload_rdata = 32'h0; cache_ack = 1'b0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t x;
      bit   ok;
      x  = q.pop_front();
      ok = (x.cyc == cyc) && (WR_wr === x.wr) && (rf_we === x.we)
        && (cp0_we === x.cp0) && (ex_commit === x.ex)
        && (flush === x.fl) && (cache_req === x.req);
      if (x.we != 0)
        ok = ok && (rf_waddr === x.wa) && (rf_wdata === x.wd);
      if (x.ex)
        ok = ok && (ex_code === x.code) && (ex_pc === x.epc)
          && (ex_badvaddr === x.bva);
      if (x.fl && !x.ex) ok = ok && (refetch_pc === x.rpc);
      if (x.req)
        ok = ok && (cache_op_o === x.op) && (cache_addr === x.addr);
      if (x.rst)
        ok = ok && (rf_waddr === 5'h0) && (rf_wdata === 32'h0)
          && (cp0_waddr === 8'h0) && (cp0_wdata === 32'h0)
          && (refetch_pc === 32'h0) && (cache_op_o === 5'h0)
          && (cache_addr === 32'h0) && (ex_pc === 32'h0);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s: got wr=%0b we=%h wa=%0d wd=%h cp0=%0b ex=%0b code=%0d epc=%h fl=%0b rpc=%h req=%0b op=%h addr=%h; want wr=%0b we=%h wa=%0d wd=%h cp0=%0b ex=%0b code=%0d epc=%h fl=%0b rpc=%h req=%0b op=%h addr=%h",
          x.nm, WR_wr, rf_we, rf_waddr, rf_wdata, cp0_we, ex_commit,
          ex_code, ex_pc, flush, refetch_pc, cache_req, cache_op_o,
          cache_addr, x.wr, x.we, x.wa, x.wd, x.cp0, x.ex, x.code,
          x.epc, x.fl, x.rpc, x.req, x.op, x.addr);
      end
    end
  end

  initial begin
    exp_t e;
    idle_in();
    reset = 1'b1;
    step();
    WR_reg_write_en = 4'hF; WR_write_reg = 5'd9;
    WR_busW_inner = 32'hDEAD_BEEF; WR_pc = 32'h40;
    WR_exception_info = 32'h1; WR_cp0_write_en = 1'b1;
    WR_cp0_write_reg = 8'h0C;
    e = mk("reset_outputs"); e.rst = 1; push(e);
    step();
    idle_in();
    reset = 1'b0;

    WR_pc = 32'h100; WR_reg_write_en = 4'hF;
    WR_write_reg = 5'd5; WR_busW_inner = 32'h1234_5678;
    e = mk("alu_commit");
    e.we = 4'hF; e.wa = 5'd5; e.wd = 32'h1234_5678; push(e);
    step();

    idle_in();
    WR_pc = 32'h8000_0100; WR_reg_write_en = 4'hF;
    WR_cp0_write_en = 1'b1; WR_badvaddr = 32'h8000_0104;
    WR_exception_info = {26'h0, 5'd4, 1'b1};
    e = mk("exception");
    e.ex = 1; e.fl = 1; e.code = 5'd4;
    e.epc = 32'h8000_0100; e.bva = 32'h8000_0104; push(e);
    step();

    idle_in();
    WR_pc = 32'h104; WR_cp0_write_en = 1'b1;
    WR_cp0_write_reg = 8'h0C; WR_busW_inner = 32'h0000_FF01;
    e = mk("cp0_write"); e.cp0 = 1; push(e);
    step();

    idle_in();
    WR_pc = 32'h108; WR_unhit = 1'b1; WR_reg_write_en = 4'h3;
    WR_write_reg = 5'd7; WR_busW_inner = 32'h5A5A_5A5A;
    e = mk("load_enter"); e.wr = 0; push(e);
    for (int i = 1; i <= 2; i++) begin
      step();
      e = mk($sformatf("load_wait%0d", i)); e.wr = 0; push(e);
    end
    step();
    dload_data_ok = 1'b1; dload_rdata = 32'hAAAA_5555;
    e = mk("load_data");
    e.we = 4'h3; e.wa = 5'd7; e.wd = 32'hAAAA_5555; push(e);
    step();
    idle_in();
    e = mk("load_back_idle"); push(e);
    step();
    dload_data_ok = 1'b1; dload_rdata = 32'h1111_2222;
    e = mk("late_data_ok"); push(e);
    step();

    idle_in();
    WR_pc = 32'h200; WR_cache_op = 5'h08;
    WR_cache_paddr = 32'h1FC0_0040; WR_crefetch = 1'b1;
    e = mk("cache_issue"); e.wr = 0; push(e);
    step();
    e = mk("cache_req1"); e.wr = 0; e.req = 1;
    e.op = 5'h08; e.addr = 32'h1FC0_0040; push(e);
    step();
    cache_ack = 1'b1;
    e = mk("cache_req2"); e.wr = 0; e.req = 1;
    e.op = 5'h08; e.addr = 32'h1FC0_0040; push(e);
    step();
    cache_ack = 1'b0;
    e = mk("cache_done"); e.fl = 1; e.rpc = 32'h204; push(e);
    step();
    idle_in();
    e = mk("cache_idle"); push(e);
    step();

    WR_pc = 32'hFFFF_FFFC; WR_inst_refetch = 1'b1;
    WR_reg_write_en = 4'hF; WR_write_reg = 5'd3;
    WR_busW_inner = 32'h0BAD_F00D;
    e = mk("refetch_wrap");
    e.we = 4'hF; e.wa = 5'd3; e.wd = 32'h0BAD_F00D;
    e.fl = 1; e.rpc = 32'h0; push(e);
    step();
    idle_in();
    WR_pc = 32'h0; WR_inst_refetch = 1'b1;
    e = mk("refetch_pc0"); e.fl = 1; e.rpc = 32'hBFC0_0000; push(e);
    step();

    idle_in();
    WR_pc = 32'h300; WR_cache_op = 5'h11;
    WR_cache_paddr = 32'h0000_1000; WR_crefetch = 1'b1;
    e = mk("rst_cache_issue"); e.wr = 0; push(e);
    step();
    e = mk("rst_cache_req"); e.wr = 0; e.req = 1;
    e.op = 5'h11; e.addr = 32'h0000_1000; push(e);
    step();
    reset = 1'b1;
    e = mk("rst_in_creq"); e.rst = 1; push(e);
    step();
    reset = 1'b0;
    idle_in();
    cache_ack = 1'b1;
    e = mk("late_ack"); push(e);
    step();
    cache_ack = 1'b0;
    e = mk("after_late_ack"); push(e);
    step();
    step();

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wr_commit.md
Name: wr_commit

Overview:
- Write-back/commit stage; consumes the WR_* outputs of the MEM->WR pipeline register.
- Commits GPR writes (byte-enabled) and CP0 writes.
- Raises exception commit and refetch flushes.
- Sequences CACHE instructions and pending uncached/miss load data via handshakes, stalling the MEM->WR register (drives its WR_wr) while busy.

Parameters:
- RESET_PC_NEXT, 32'hBFC0_0000, redirect target used only if a refetch commits with WR_pc==0 (sanity fallback).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- WR_pc  in  32  committing instruction PC
- WR_busW_inner  in  32  GPR write data (non-pending)
- WR_badvaddr  in  32  faulting address
- WR_write_reg  in  5  GPR destination
- WR_reg_write_en  in  4  GPR byte write enables
- WR_cp0_write_en  in  1  CP0 write request
- WR_cp0_write_reg  in  8  CP0 {sel,reg}
- WR_exception_info  in  `EX_INFO  bit0 = exception valid, [5:1] = ExcCode, rest per reg_defines.v
- WR_inst_refetch  in  1  refetch after commit
- WR_unhit  in  1  load data still pending from dcache
- WR_cache_op  in  5  CACHE op code, 0 = none
- WR_crefetch  in  1  refetch after CACHE op
- WR_cache_paddr  in  32  CACHE op physical address
- dload_data_ok  in  1  pending load data valid
- dload_rdata  in  32  pending load data
- cache_ack  in  1  cache controller accepted and finished op
- WR_wr  out  1  enable for MEM->WR register (0 = stall)
- rf_we  out  4  GPR byte write enables
- rf_waddr  out  5  GPR address
- rf_wdata  out  32  GPR data
- cp0_we  out  1  CP0 write strobe
- cp0_waddr  out  8  CP0 address
- cp0_wdata  out  32  = WR_busW_inner
- ex_commit  out  1  exception taken pulse
- ex_code  out  5  ExcCode
- ex_pc  out  32  EPC source
- ex_badvaddr  out  32  BadVAddr source
- flush  out  1  pipeline flush pulse
- refetch_pc  out  32  fetch redirect for refetch flush
- cache_req  out  1  CACHE op request
- cache_op_o  out  5  op code
- cache_addr  out  32  op address

Behaviour:
- States: IDLE, LWAIT, CREQ, CDONE. Reset -> IDLE. While reset is high every output is 0 except WR_wr=1.
- Instruction valid = exception bit | (|WR_reg_write_en) | WR_cp0_write_en | (|WR_cache_op) | WR_inst_refetch.
- Priority in IDLE:
  - exception: ex_commit=flush=1 same cycle, all writes suppressed; stay IDLE. ex_code, ex_pc=WR_pc and ex_badvaddr are valid that cycle.
  - cache_op!=0: WR_wr=0 and writes suppressed -> CREQ next cycle.
  - unhit: WR_wr=0 and rf_we=0 -> LWAIT.
  - otherwise: commit combinationally in the same cycle.
    - rf_we=WR_reg_write_en and cp0_we=WR_cp0_write_en.
    - If WR_inst_refetch: flush=1, refetch_pc=WR_pc+4.
- LWAIT: WR_wr=0. On dload_data_ok the same cycle: rf_we=WR_reg_write_en, rf_wdata=dload_rdata, WR_wr=1 -> IDLE. reg_write_en==0 with unhit still waits for data_ok.
- CREQ:
  - cache_req=1, op/addr stable until cache_ack (ack may arrive in the first CREQ cycle) -> CDONE. WR_wr=0.
  - cache_req drops in the cycle after ack.
- CDONE (1 cycle): WR_wr=1, flush=WR_crefetch, refetch_pc=WR_pc+4 -> IDLE.
- rf_waddr/rf_wdata/cp0_* mirror inputs whenever the matching we is 0 (don't-care for consumers).
- Reset mid-LWAIT/CREQ: next cycle IDLE, cache_req=0; late ack/data_ok ignored in IDLE.
- refetch_pc is WR_pc+4 modulo 2^32 (wraps); RESET_PC_NEXT if WR_pc==0.

Optional Feature:
- DEBUG_TRACE_EN defined: add outputs debug_wb_pc[32], debug_wb_rf_wen[4], debug_wb_rf_wnum[5], debug_wb_rf_wdata[32].
  - They equal WR_pc, rf_we, rf_waddr, rf_wdata in every cycle rf_we!=0, and are 0 otherwise.
- Undefined: ports and logic absent.

Decomposition:
- reg_defines.v carries:
  - `EX_INFO width
  - exception bit positions (EX_VALID bit, EXCCODE range)
  - cache op encodings
  - FSM state localparams (2-bit)
- One natural sub-module: wr_cache_seq, holding the CREQ/CDONE handshake and cache_req/op/addr outputs. wr_commit instantiates it and owns LWAIT and commit muxing.

Test Plan:
- Plain ALU commit: reg_write_en=4'hF, write_reg=5, busW=32'h1234_5678 -> same cycle rf_we=F, rf_waddr=5, rf_wdata=32'h1234_5678, WR_wr=1, flush=0.
- Exception with reg_write_en=F, pc=32'h8000_0100, ExcCode=4 -> ex_commit=1, flush=1, ex_pc=32'h8000_0100, rf_we=0, cp0_we=0.
- Pending load: unhit=1, we=4'h3; dload_data_ok after 3 cycles with rdata=32'hAAAA_5555 -> WR_wr=0 for 3 cycles, then rf_we=3, rf_wdata=32'hAAAA_5555, back to IDLE.
- CACHE op 5'h08, paddr=32'h1FC0_0040, crefetch=1, ack after 2 cycles -> cache_req high 2 cycles with stable op/addr, then CDONE: flush=1, refetch_pc=WR_pc+4.
- Refetch instruction at pc=32'hFFFF_FFFC -> commit plus flush, refetch_pc=32'h0000_0000 (wrap).
- Reset asserted during CREQ, then ack after reset deassert -> cache_req=0, state IDLE, ack ignored, no flush.
